// File: rtl/spi_slave_capture.sv
// spi_slave_capture: oversampled SPI mode-0 slave. Serial words from the master
// are packed MSB first into an RX FIFO, and TX words are shifted back on spi_sdo.
// All SPI lines are synchronised into clk, so clk must run at least 8x spi_clk.
module spi_slave_capture #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          spi_clk,
   input  logic                          spi_csn,
   input  logic                          spi_sdi,
   output logic                          spi_sdo,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   input  logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          overflow,
   output logic                          underflow,
   input  logic                          flag_clr,
   output logic                          frame_err
);

   localparam int CW    = $clog2(DATA_WIDTH);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t                state_q, state_d;
   logic [2:0]            clk_sync, csn_sync;
   logic [1:0]            sdi_sync;
   logic [2:0]            vld_pipe;
   logic                  armed;
   logic                  clk_rise, clk_fall, csn_fall, csn_rise;
   logic                  do_load, bit_rise, bit_fall, abort;
   logic                  word_done, reload, pop, push_ok;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] rx_sr, tx_sr, rx_word;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;

   // Synchronisers plus arming: after reset the csn chain must first show a real
   // high level, so a frame already in progress at reset release is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= 3'b000;
         csn_sync <= 3'b111;
         sdi_sync <= 2'b00;
         vld_pipe <= 3'b000;
         armed    <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[1:0], spi_clk};
         csn_sync <= {csn_sync[1:0], spi_csn};
         sdi_sync <= {sdi_sync[0], spi_sdi};
         vld_pipe <= {vld_pipe[1:0], 1'b1};
         armed    <= armed | (vld_pipe[2] & csn_sync[2]);
      end
   end

   assign clk_rise = clk_sync[1] & ~clk_sync[2];
   assign clk_fall = ~clk_sync[1] & clk_sync[2];
   assign csn_fall = armed & ~csn_sync[1] & csn_sync[2];
   assign csn_rise = csn_sync[1] & ~csn_sync[2];

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and per-cycle action decode; csn rising overrides everything
   always_comb begin
      state_d  = state_q;
      do_load  = 1'b0;
      bit_rise = 1'b0;
      bit_fall = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE:    if (csn_fall) state_d = LOAD;
         LOAD:    begin do_load = 1'b1; state_d = SHIFT; end
         SHIFT:   begin bit_rise = clk_rise; bit_fall = clk_fall; end
         default: state_d = IDLE;
      endcase
      if (csn_rise) begin
         state_d  = IDLE;
         abort    = (state_q != IDLE);
         do_load  = 1'b0;
         bit_rise = 1'b0;
         bit_fall = 1'b0;
      end
   end

   assign word_done = bit_rise && (bit_cnt == LAST_BIT);
   assign reload    = do_load | word_done;
   assign tx_ready  = reload & tx_valid;
   assign rx_word   = {rx_sr[DATA_WIDTH-2:0], sdi_sync[1]};
   assign pop       = rx_valid & rx_ready;
   assign push_ok   = word_done && ((rx_count != FULL_CNT) || pop);

   // Shift registers and bit counter. A falling edge right after a (re)load
   // (bit_cnt == 0) must not shift, or the new MSB would be skipped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         tx_sr   <= '0;
         spi_sdo <= 1'b0;
      end else if (csn_rise) begin
         bit_cnt <= '0;
         spi_sdo <= 1'b0;
      end else begin
         if (bit_rise) begin
            rx_sr   <= rx_word;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
         end
         if (do_load) bit_cnt <= '0;
         if (reload) begin
            tx_sr   <= tx_valid ? tx_data : '0;
            spi_sdo <= tx_valid & tx_data[DATA_WIDTH-1];
         end else if (bit_fall && bit_cnt != '0) begin
            tx_sr   <= tx_sr << 1;
            spi_sdo <= tx_sr[DATA_WIDTH-2];
         end
      end
   end

   // Sticky flags (a set in the same cycle as flag_clr wins) and frame error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= abort && (bit_cnt != '0);
         if (word_done && !push_ok) overflow <= 1'b1;
         else if (flag_clr)         overflow <= 1'b0;
         if (reload && !tx_valid)   underflow <= 1'b1;
         else if (flag_clr)         underflow <= 1'b0;
      end
   end

   // RX FIFO; a push into a full FIFO is legal when the head is popped that cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_count <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= rx_word;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      rx_count <= rx_count + CNT_W'(1);
         else if (!push_ok && pop) rx_count <= rx_count - CNT_W'(1);
      end
   end

   assign rx_valid = (rx_count != '0);
   assign rx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_spi_slave_capture.sv
// Bench for spi_slave_capture: SPI master driver, table of single-word frames,
// hand-written corner sequences and a randomized run against a queue model.
module tb_spi_slave_capture;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          spi_clk = 1'b0, spi_csn = 1'b1, spi_sdi = 1'b0;
   logic          spi_sdo;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready = 1'b0;
   logic [3:0]    rx_count;
   logic [DW-1:0] tx_data;
   logic          tx_valid = 1'b0;
   logic          tx_ready, overflow, underflow, frame_err;
   logic          flag_clr = 1'b0;

   spi_slave_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_csn(spi_csn),
      .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_count(rx_count), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .overflow(overflow), .underflow(underflow),
      .flag_clr(flag_clr), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // TX word source: advances on every consumed word
   logic [31:0] tx_words [64];
   int          tx_idx = 0;
   logic        tx_rst = 1'b0;
   assign tx_data = tx_words[tx_idx[5:0]];
   always @(posedge clk) begin
      if (tx_rst)        tx_idx <= 0;
      else if (tx_ready) tx_idx <= tx_idx + 1;
   end

   int fe_cnt = 0;
   always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

   int          n_vec = 0, n_err = 0;
   logic [31:0] mosi_buf [16];
   logic [31:0] miso_buf [16];
   int          ld_at_last;
   logic [31:0] popped_head;
   logic [3:0]  cnt_at_pop;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic half();
      repeat (5) @(negedge clk);
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0; @(negedge clk);
   endtask

   task automatic pulse_txrst();
      tx_rst = 1'b1; @(negedge clk); tx_rst = 1'b0; @(negedge clk);
   endtask

   task automatic pop_chk(input string nm, input logic [31:0] exp);
      chk(nm, rx_data, exp);
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0; @(negedge clk);
   endtask

   // One mode-0 bit: data set while clock low, master samples spi_sdo at the rise
   task automatic spi_bit(input int i, input bit pop_last, input bit last);
      int w, b;
      w = i / 32;
      b = 31 - (i % 32);
      spi_sdi = mosi_buf[w][b];
      half();
      miso_buf[w][b] = spi_sdo;
      spi_clk = 1'b1;
      if (last) ld_at_last = tx_idx;
      if (pop_last && last) begin
         // pop lands on the same clk edge as the word push
         repeat (2) @(negedge clk);
         popped_head = rx_data;
         cnt_at_pop  = rx_count;
         rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
         repeat (2) @(negedge clk);
      end else half();
      spi_clk = 1'b0;
   endtask

   task automatic spi_frame(input int nbits, input bit pop_last);
      spi_csn = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) spi_bit(i, pop_last, i == nbits - 1);
      half();
      spi_csn = 1'b1;
      spi_sdi = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] mosi;
      logic [31:0] tx;
      logic        txv;
      logic [31:0] exp_rx;
      logic [31:0] exp_miso;
      logic        exp_und;
      int          exp_ld;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] q [$];
   int          mp, fe0, nw, np;
   logic        txv, ovf_m, und_m;

   initial begin
      tbl[0] = '{32'hA5C3_0F96, 32'h1234_5678, 1'b1, 32'hA5C3_0F96, 32'h1234_5678, 1'b0, 1};
      tbl[1] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0};
      tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1};
      tbl[3] = '{32'h8000_0001, 32'h8000_0001, 1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0, 1};
      tbl[4] = '{32'h5555_AAAA, 32'h0F0F_0F0F, 1'b1, 32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, 1};
      tbl[5] = '{32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 32'h1357_9BDF, 32'h0000_0000, 1'b1, 0};
      for (int i = 0; i < 64; i++) tx_words[i] = 32'h0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst spi_sdo", 32'(spi_sdo), 0);
      chk("rst rx_valid", 32'(rx_valid), 0);
      chk("rst rx_count", 32'(rx_count), 0);
      chk("rst rx_data", rx_data, 0);
      chk("rst tx_ready", 32'(tx_ready), 0);
      chk("rst overflow", 32'(overflow), 0);
      chk("rst underflow", 32'(underflow), 0);
      chk("rst frame_err", 32'(frame_err), 0);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);

      // single-word frames from the table
      for (int v = 0; v < 6; v++) begin
         pulse_clr();
         tx_words[0] = tbl[v].tx;
         tx_words[1] = ~tbl[v].tx;
         tx_valid    = tbl[v].txv;
         pulse_txrst();
         mosi_buf[0] = tbl[v].mosi;
         fe0 = fe_cnt;
         spi_frame(32, 1'b0);
         chk("tbl rx_count", 32'(rx_count), 1);
         chk("tbl miso", miso_buf[0], tbl[v].exp_miso);
         chk("tbl underflow", 32'(underflow), 32'(tbl[v].exp_und));
         chk("tbl overflow", 32'(overflow), 0);
         chk("tbl tx loads", 32'(ld_at_last), 32'(tbl[v].exp_ld));
         chk("tbl frame_err", 32'(fe_cnt - fe0), 0);
         pop_chk("tbl rx_data", tbl[v].exp_rx);
         chk("tbl rx_count after pop", 32'(rx_count), 0);
      end

      // 9 words into an 8-deep FIFO: word 9 is dropped
      pulse_clr();
      tx_valid = 1'b1;
      for (int k = 0; k < 9; k++) mosi_buf[k] = 32'hC0DE_0000 | 32'(k + 1);
      spi_frame(9 * 32, 1'b0);
      chk("ovf rx_count", 32'(rx_count), 8);
      chk("ovf overflow", 32'(overflow), 1);
      for (int k = 0; k < 8; k++) pop_chk("ovf order", 32'hC0DE_0000 | 32'(k + 1));
      chk("ovf drained", 32'(rx_count), 0);
      pulse_clr();
      chk("ovf cleared", 32'(overflow), 0);

      // csn rises after 13 bits
      fe0 = fe_cnt;
      mosi_buf[0] = 32'hBEEF_1234;
      spi_frame(13, 1'b0);
      chk("ferr pulses", 32'(fe_cnt - fe0), 1);
      chk("ferr rx_count", 32'(rx_count), 0);
      mosi_buf[0] = 32'h0BAD_F00D;
      spi_frame(32, 1'b0);
      chk("ferr next count", 32'(rx_count), 1);
      chk("ferr no new pulse", 32'(fe_cnt - fe0), 1);
      pop_chk("ferr next word", 32'h0BAD_F00D);

      // full FIFO: push and pop in the same cycle
      pulse_clr();
      for (int k = 0; k < 8; k++) mosi_buf[k] = 32'h7700_0000 | 32'(k);
      spi_frame(8 * 32, 1'b0);
      chk("pp fill", 32'(rx_count), 8);
      mosi_buf[0] = 32'h7700_00AA;
      spi_frame(32, 1'b1);
      chk("pp count at pop", 32'(cnt_at_pop), 8);
      chk("pp popped head", popped_head, 32'h7700_0000);
      chk("pp rx_count", 32'(rx_count), 8);
      chk("pp overflow", 32'(overflow), 0);
      for (int k = 1; k < 8; k++) pop_chk("pp order", 32'h7700_0000 | 32'(k));
      pop_chk("pp new word", 32'h7700_00AA);

      // reset in the middle of a frame
      tx_valid = 1'b0;
      mosi_buf[0] = 32'h0000_0012;
      spi_frame(32, 1'b0);
      chk("mid pre count", 32'(rx_count), 1);
      chk("mid pre underflow", 32'(underflow), 1);
      tx_valid = 1'b1;
      mosi_buf[0] = 32'hFFFF_FFFF;
      fe0 = fe_cnt;
      spi_csn = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 20; i++) spi_bit(i, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid spi_sdo", 32'(spi_sdo), 0);
      chk("mid rx_valid", 32'(rx_valid), 0);
      chk("mid rx_count", 32'(rx_count), 0);
      chk("mid rx_data", rx_data, 0);
      chk("mid tx_ready", 32'(tx_ready), 0);
      chk("mid underflow", 32'(underflow), 0);
      chk("mid overflow", 32'(overflow), 0);
      chk("mid frame_err", 32'(frame_err), 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 20; i < 32; i++) spi_bit(i, 1'b0, 1'b0);
      half();
      spi_csn = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid tail ignored", 32'(rx_count), 0);
      chk("mid tail no ferr", 32'(fe_cnt - fe0), 0);
      mosi_buf[0] = 32'h0000_0001;
      spi_frame(32, 1'b0);
      chk("mid next count", 32'(rx_count), 1);
      pop_chk("mid next word", 32'h0000_0001);

      // randomized frames against a queue model
      pulse_clr();
      for (int i = 0; i < 64; i++) tx_words[i] = $urandom;
      pulse_txrst();
      mp = 0; ovf_m = 1'b0; und_m = 1'b0;
      q.delete();
      for (int f = 0; f < 12; f++) begin
         nw  = $urandom_range(1, 3);
         txv = ($urandom_range(0, 3) != 0);
         tx_valid = txv;
         for (int k = 0; k < nw; k++) mosi_buf[k] = $urandom;
         spi_frame(nw * 32, 1'b0);
         for (int k = 0; k < nw; k++) begin
            chk("rnd miso", miso_buf[k], txv ? tx_words[(mp + k) % 64] : 32'h0);
            if (q.size() < DEPTH) q.push_back(mosi_buf[k]);
            else ovf_m = 1'b1;
         end
         if (txv) mp = mp + nw + 1;
         else     und_m = 1'b1;
         chk("rnd rx_count", 32'(rx_count), 32'(q.size()));
         chk("rnd overflow", 32'(overflow), 32'(ovf_m));
         chk("rnd underflow", 32'(underflow), 32'(und_m));
         chk("rnd tx consumed", 32'(tx_idx), 32'(mp));
         np = $urandom_range(0, q.size());
         for (int p = 0; p < np; p++) pop_chk("rnd rx_data", q.pop_front());
         if ($urandom_range(0, 2) == 0) begin
            pulse_clr();
            ovf_m = 1'b0;
            und_m = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
